// File: rtl/video_timing_pipe.sv
// Raster timing generator and pixel source (solid/bars/stream/checker) feeding a DVI encoder.
// Latency PIPE_DELAY clk from stage-0 raster position to outputs; stream is never stalled (underflow shows black).
module video_timing_pipe #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int COLOR_W    = 8,
    parameter int PIPE_DELAY = 2,
    parameter int CHK_LOG2   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    input  logic [3*COLOR_W-1:0]   s_data,
    input  logic                   s_sof,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   clr_flags,
    output logic [15:0]            sx,
    output logic [15:0]            sy,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [3*COLOR_W-1:0]   rgb,
    output logic                   frame_start,
    output logic                   underflow,
    output logic                   sof_err
);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_ACT_L  = 16'(H_ACTIVE);
    localparam logic [15:0] H_SB_L   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SE_L   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] H_LAST_L = 16'(H_TOT - 1);
    localparam logic [15:0] V_ACT_L  = 16'(V_ACTIVE);
    localparam logic [15:0] V_SB_L   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SE_L   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_LAST_L = 16'(V_TOT - 1);
    localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);

    localparam logic [1:0] MODE_SOLID  = 2'd0;
    localparam logic [1:0] MODE_BARS   = 2'd1;
    localparam logic [1:0] MODE_STREAM = 2'd2;
    localparam logic [1:0] MODE_CHK    = 2'd3;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             de;
        logic             fs;
        logic [PIX_W-1:0] pix;
    } stage_t;

    logic [15:0] sx_q, sx_d, sy_q, sy_d;
    logic [15:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  mode_q, mode_d, mode_eff;
    logic        underflow_q, underflow_d, sof_err_q, sof_err_d;
    stage_t      pipe_q [PIPE_DELAY];
    stage_t      pipe_d [PIPE_DELAY];

    logic             origin, de0, hs0, vs0, accept, chk_bit;
    logic [PIX_W-1:0] pix0, bar_rgb;

    always_comb begin
        origin = (sx_q == 16'd0) && (sy_q == 16'd0);

        sx_d = sx_q + 16'd1;
        sy_d = sy_q;
        if (sx_q == H_LAST_L) begin
            sx_d = 16'd0;
            sy_d = (sy_q == V_LAST_L) ? 16'd0 : sy_q + 16'd1;
        end

        // Bar index advances every H_ACTIVE/8 pixels and restarts with each line.
        bar_cnt_d = bar_cnt_q + 16'd1;
        bar_idx_d = bar_idx_q;
        if (sx_q == H_LAST_L) begin
            bar_cnt_d = 16'd0;
            bar_idx_d = 3'd0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = 16'd0;
            bar_idx_d = bar_idx_q + 3'd1;
        end

        // The mode input is sampled at (0,0) so the whole frame, including its first pixel, uses it.
        mode_eff = origin ? mode : mode_q;
        mode_d   = mode_eff;

        de0 = (sx_q < H_ACT_L) && (sy_q < V_ACT_L);
        hs0 = (sx_q >= H_SB_L) && (sx_q < H_SE_L);
        vs0 = (sy_q >= V_SB_L) && (sy_q < V_SE_L);

        bar_rgb = {{COLOR_W{~bar_idx_q[1]}}, {COLOR_W{~bar_idx_q[2]}}, {COLOR_W{~bar_idx_q[0]}}};
        chk_bit = sx_q[CHK_LOG2] ^ sy_q[CHK_LOG2];

        s_ready = !rst && (mode_eff == MODE_STREAM) && de0;
        accept  = s_ready && s_valid;

        case (mode_eff)
            MODE_SOLID:  pix0 = solid_rgb;
            MODE_BARS:   pix0 = bar_rgb;
            MODE_STREAM: pix0 = accept ? s_data : '0;
            MODE_CHK:    pix0 = chk_bit ? '0 : '1;
            default:     pix0 = '0;
        endcase

        underflow_d = (s_ready && !s_valid) || (underflow_q && !clr_flags);
        sof_err_d   = (accept && (s_sof != origin)) || (sof_err_q && !clr_flags);

        pipe_d[0] = '{hs: hs0, vs: vs0, de: de0, fs: origin, pix: pix0};
        for (int i = 1; i < PIPE_DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sx_q        <= 16'd0;
            sy_q        <= 16'd0;
            bar_cnt_q   <= 16'd0;
            bar_idx_q   <= 3'd0;
            mode_q      <= mode;
            underflow_q <= 1'b0;
            sof_err_q   <= 1'b0;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            mode_q      <= mode_d;
            underflow_q <= underflow_d;
            sof_err_q   <= sof_err_d;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign sx          = sx_q;
    assign sy          = sy_q;
    assign hsync       = pipe_q[PIPE_DELAY-1].hs ? HS_POL : ~HS_POL;
    assign vsync       = pipe_q[PIPE_DELAY-1].vs ? VS_POL : ~VS_POL;
    assign de          = pipe_q[PIPE_DELAY-1].de;
    assign rgb         = pipe_q[PIPE_DELAY-1].de ? pipe_q[PIPE_DELAY-1].pix : '0;
    assign frame_start = pipe_q[PIPE_DELAY-1].fs;
    assign underflow   = underflow_q;
    assign sof_err     = sof_err_q;
endmodule

// File: tb/tb_video_timing_pipe.sv
// Scoreboard bench for video_timing_pipe on a small 24x12 raster.
module tb_video_timing_pipe;
    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 8, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = 24, VT = 12, PD = 2;
    localparam bit HSP = 1'b1, VSP = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [23:0] solid_rgb, s_data, rgb;
    logic        s_sof, s_valid, s_ready, clr_flags;
    logic [15:0] sx, sy;
    logic        hsync, vsync, de, frame_start, underflow, sof_err;

    always #5 clk = ~clk;

    video_timing_pipe #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(8), .PIPE_DELAY(PD), .CHK_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
        .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
        .clr_flags(clr_flags), .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync),
        .de(de), .rgb(rgb), .frame_start(frame_start),
        .underflow(underflow), .sof_err(sof_err)
    );

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
    } out_t;

    typedef struct packed {
        logic [15:0] sx;
        logic [15:0] sy;
        logic        rdy;
        logic        uf;
        logic        se;
    } pos_t;

    localparam out_t BLANK = '{hsync: ~HSP, vsync: ~VSP, de: 1'b0, fs: 1'b0, rgb: 24'h0};

    out_t exp_q[$];
    pos_t pos_q[$];
    int   total = 0;
    int   bad = 0;
    int   de_cnt = 0, acc_cnt = 0, cyc = 0;
    int   fs_times[$];

    // Bench-side raster model and stimulus configuration
    int          bx = 0, by = 0;
    logic        prev_rst = 1'b1, prev_clr = 1'b0;
    logic        ev_uf = 1'b0, ev_se = 1'b0, m_uf = 1'b0, m_se = 1'b0;
    logic [1:0]  mode_lat = 2'd0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [23:0] cfg_solid = 24'h00B4FF;
    logic        cfg_rst = 1'b1, cfg_clr = 1'b0;
    int          drop_x = -1, drop_y = -1, sof_x = 0, sof_y = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] sdat(int x, int y);
        return {8'(x * 13 + 7), 8'(y * 29 + 3), 8'(x + y * 16)};
    endfunction

    task automatic tick();
        logic        org, de0, hs0, vs0, rdy;
        logic [1:0]  eff;
        logic [23:0] pix;
        out_t        e;
        @(posedge clk);
        #1;
        if (prev_rst) begin
            bx = 0; by = 0; m_uf = 1'b0; m_se = 1'b0;
        end else begin
            m_uf = ev_uf | (m_uf & ~prev_clr);
            m_se = ev_se | (m_se & ~prev_clr);
            if (bx == HT - 1) begin
                bx = 0;
                by = (by == VT - 1) ? 0 : by + 1;
            end else begin
                bx = bx + 1;
            end
        end
        rst       = cfg_rst;
        clr_flags = cfg_clr;
        mode      = cfg_mode;
        solid_rgb = cfg_solid;
        org       = (bx == 0) && (by == 0);
        if (org) mode_lat = cfg_mode;
        eff       = mode_lat;
        de0       = (bx < HA) && (by < VA);
        hs0       = (bx >= 18) && (bx <= 20);
        vs0       = (by >= 9) && (by <= 10);
        s_data    = sdat(bx, by);
        s_sof     = (bx == sof_x) && (by == sof_y);
        s_valid   = !((bx == drop_x) && (by == drop_y));
        rdy       = !cfg_rst && (eff == 2'd2) && de0;
        ev_uf     = rdy && !s_valid;
        ev_se     = rdy && s_valid && (s_sof != org);
        case (eff)
            2'd0:    pix = cfg_solid;
            2'd1:    pix = de0 ? bars[bx / 2] : 24'h0;
            2'd2:    pix = s_valid ? s_data : 24'h0;
            default: pix = ((((bx >> 2) ^ (by >> 2)) & 1) != 0) ? 24'h0 : 24'hFFFFFF;
        endcase
        e = '{hsync: hs0 ? HSP : ~HSP, vsync: vs0 ? VSP : ~VSP, de: de0, fs: org,
              rgb: de0 ? pix : 24'h0};
        if (cfg_rst) e = BLANK;
        pos_q.push_back('{sx: 16'(bx), sy: 16'(by), rdy: rdy, uf: m_uf, se: m_se});
        exp_q.push_back(e);
        prev_rst = cfg_rst;
        prev_clr = cfg_clr;
        cfg_clr  = 1'b0;
    endtask

    task automatic run_to(int x, int y);
        int budget = 400;
        while (!((bx == x) && (by == y)) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            total++; bad++;
            $display("FAIL run_to(%0d,%0d): position not reached, model at (%0d,%0d)", x, y, bx, by);
        end
    endtask

    task automatic check(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    // Monitor: pops and compares whatever the DUT presents each cycle
    logic mon_prev_rst = 1'b1;
    always @(negedge clk) begin
        pos_t p;
        out_t e, a;
        cyc++;
        if (pos_q.size() > 0) begin
            p = pos_q.pop_front();
            total++;
            if ({sx, sy, s_ready, underflow, sof_err} !== p) begin
                bad++;
                $display("FAIL stage0 @t=%0t: got sx=%0d sy=%0d rdy=%b uf=%b se=%b want sx=%0d sy=%0d rdy=%b uf=%b se=%b",
                         $time, sx, sy, s_ready, underflow, sof_err, p.sx, p.sy, p.rdy, p.uf, p.se);
            end
        end
        if (exp_q.size() == PD + 1) begin
            e = exp_q.pop_front();
            if (mon_prev_rst) e = BLANK;
            a = '{hsync: hsync, vsync: vsync, de: de, fs: frame_start, rgb: rgb};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL output @t=%0t: got hs=%b vs=%b de=%b fs=%b rgb=%06h want hs=%b vs=%b de=%b fs=%b rgb=%06h",
                         $time, a.hsync, a.vsync, a.de, a.fs, a.rgb, e.hsync, e.vsync, e.de, e.fs, e.rgb);
            end
        end
        if (s_valid && s_ready) acc_cnt++;
        if (de) de_cnt++;
        if (frame_start) fs_times.push_back(cyc);
        mon_prev_rst = rst;
    end

    initial begin
        rst = 1'b1; mode = 2'd0; solid_rgb = 24'h00B4FF; s_data = 24'h0;
        s_sof = 1'b0; s_valid = 1'b1; clr_flags = 1'b0;

        // Reset, then two frames of solid colour
        repeat (3) tick();
        cfg_rst = 1'b0;
        de_cnt  = 0;
        fs_times.delete();
        repeat (2 * HT * VT) tick();
        check("de_count_2frames", de_cnt, 256);
        check("frame_start_count", fs_times.size(), 2);
        check("frame_interval", (fs_times.size() >= 2) ? fs_times[1] - fs_times[0] : -1, 288);

        // Colour bars from the next frame
        cfg_mode = 2'd1;
        repeat (2 * HT * VT) tick();

        // Stream, always valid, s_sof on first beat
        cfg_mode = 2'd2;
        acc_cnt  = 0;
        repeat (HT * VT) tick();
        check("beats_per_frame", acc_cnt, 128);

        // Single-beat underflow at (5,3), then clear
        drop_x = 5; drop_y = 3;
        run_to(10, 3);
        drop_x = -1; drop_y = -1;
        check("underflow_sticky", int'(underflow), 1);
        cfg_clr = 1'b1;
        tick();
        tick();
        check("underflow_cleared", int'(underflow), 0);
        run_to(HT - 1, VT - 1);

        // s_sof on the beat at (1,0)
        sof_x = 1; sof_y = 0;
        repeat (HT * VT) tick();
        check("sof_err_set", int'(sof_err), 1);
        sof_x = 0;
        cfg_clr = 1'b1;
        tick();
        run_to(HT - 1, VT - 1);

        // Solid, switch to checker mid-frame, reset in the checker frame
        cfg_mode = 2'd0;
        repeat (HT * VT) tick();
        run_to(0, 4);
        cfg_mode = 2'd3;
        run_to(HT - 1, VT - 1);
        run_to(0, 6);
        cfg_rst = 1'b1;
        repeat (2) tick();
        cfg_rst = 1'b0;
        fs_times.delete();
        repeat (HT * VT + 12) tick();
        check("frame_start_after_rst", fs_times.size(), 2);

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
